// File: rtl/div_pkg.sv
// Shared widths and FSM encoding for the restoring divider.
package div_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   rem_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_out,
    output logic          q_bit
);

    logic [VW+1:0] shifted;
    logic [VW:0]   diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {2'b00, divisor});
        // Only the low VW+1 bits can be non-zero when the trial difference is kept.
        diff    = shifted[VW:0] - {1'b0, divisor};
        rem_out = q_bit ? diff : shifted[VW:0];
    end

endmodule

// File: rtl/div8by4.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per cycle.
module div8by4
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quot,
    output logic [VW-1:0] rem,
    output logic          dbz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [VW:0]   prem;
    logic [CW-1:0] cnt;
    logic          zero;
    logic [VW:0]   step_rem;
    logic          step_q;

    div_step #(.VW(VW)) u_step (
        .rem_in  (prem),
        .bit_in  (dvd[DW-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign accept = start && (state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (zero || cnt == '0) state_nxt = DONE;
            DONE: state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // dvd doubles as the quotient register: dividend bits shift out the top, quotient bits in the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd  <= '0;
            dvs  <= '0;
            prem <= '0;
            cnt  <= '0;
            zero <= 1'b0;
            quot <= '0;
            rem  <= '0;
            dbz  <= 1'b0;
        end else if (accept) begin
            dvd  <= dividend;
            dvs  <= divisor;
            prem <= '0;
            cnt  <= CW'(DW - 1);
            zero <= (divisor == '0);
        end else if (state == RUN) begin
            if (zero) begin
                quot <= '1;
                rem  <= dvd[VW-1:0];
                dbz  <= 1'b1;
            end else begin
                dvd  <= {dvd[DW-2:0], step_q};
                prem <= step_rem;
                cnt  <= cnt - 1'b1;
                if (cnt == '0) begin
                    quot <= {dvd[DW-2:0], step_q};
                    rem  <= step_rem[VW-1:0];
                    dbz  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_div8by4.sv
// Directed and randomized bench for div8by4 against an arithmetic reference model.
module tb_div8by4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quot;
    logic [3:0] rem;
    logic       dbz;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] last_q = '0;
    logic [3:0] last_r = '0;
    logic       last_d = 1'b0;

    div8by4 #(.DW(8), .VW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r, output logic d);
        if (b == 4'd0) begin
            q = 8'hFF;
            r = a[3:0];
            d = 1'b1;
        end else begin
            q = 8'(int'(a) / int'(b));
            r = 4'(int'(a) % int'(b));
            d = 1'b0;
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = 8'($urandom);
        divisor = 4'($urandom);
    endtask

    // Waits for done while checking busy and held outputs; optional poke of a stray start.
    task automatic wait_run(input string tag, input int lat, input int poke, input bit keep);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            chk({tag, "_run"}, {18'd0, busy, quot, rem, dbz}, {18'd0, 1'b1, last_q, last_r, last_d});
            if (cyc == poke) begin
                start = 1'b1;
                dividend = 8'd9;
                divisor = 4'd2;
            end else if (!keep) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, cyc, lat);
    endtask

    task automatic result(input string tag, input logic [7:0] a, input logic [3:0] b);
        logic [7:0] eq;
        logic [3:0] er;
        logic       ed;
        model(a, b, eq, er, ed);
        chk({tag, "_res"}, {17'd0, busy, done, quot, rem, dbz}, {17'd0, 1'b0, 1'b1, eq, er, ed});
        last_q = eq;
        last_r = er;
        last_d = ed;
    endtask

    task automatic idle_after(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {30'd0, busy, done}, 32'd0);
    endtask

    task automatic do_div(input string tag, input logic [7:0] a, input logic [3:0] b);
        issue(a, b);
        wait_run(tag, (b == 4'd0) ? 1 : 8, -1, 1'b0);
        result(tag, a, b);
        idle_after(tag);
    endtask

    initial begin
        logic seen;
        #12;
        chk("reset", {17'd0, busy, done, quot, rem, dbz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_div("d200_7", 8'd200, 4'd7);
        do_div("d255_1", 8'd255, 4'd1);
        do_div("d0_15", 8'd0, 4'd15);
        do_div("d15_15", 8'd15, 4'd15);
        do_div("d37_0", 8'd37, 4'd0);
        do_div("d37_3", 8'd37, 4'd3);

        // Stray start with 9/2 during the third RUN cycle must be ignored.
        issue(8'd100, 4'd9);
        wait_run("ign", 8, 2, 1'b0);
        result("ign", 8'd100, 4'd9);
        idle_after("ign");

        // Asynchronous reset in the fourth RUN cycle.
        issue(8'd123, 4'd5);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {17'd0, busy, done, quot, rem, dbz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen = seen | done | busy;
        end
        chk("rst_nodone", {31'd0, seen}, 32'd0);
        last_q = '0;
        last_r = '0;
        last_d = 1'b0;
        do_div("d50_6", 8'd50, 4'd6);

        // Back-to-back: start held through done.
        @(negedge clk);
        start = 1'b1;
        dividend = 8'd60;
        divisor = 4'd4;
        @(posedge clk);
        #1;
        dividend = 8'd61;
        wait_run("b2b_a", 8, -1, 1'b1);
        result("b2b_a", 8'd60, 4'd4);
        @(posedge clk);
        #1;
        chk("b2b_gap", {30'd0, busy, done}, 32'd2);
        start = 1'b0;
        wait_run("b2b_b", 8, -1, 1'b0);
        result("b2b_b", 8'd61, 4'd4);
        idle_after("b2b_b");

        for (int i = 0; i < 24; i++) begin
            do_div("rand", 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div8by4.md
DIV8BY4 -- requirements
Module: div8by4

Interface
REQ-001 SHALL have parameter DW, default 8, meaning dividend and quotient width.
REQ-002 SHALL have parameter VW, default 4, meaning divisor and remainder width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request a division; sampled only when busy is low.
REQ-006 SHALL have port dividend, input, DW, unsigned dividend, captured on the accepting edge.
REQ-007 SHALL have port divisor, input, VW, unsigned divisor, captured on the accepting edge.
REQ-008 SHALL have port busy, output, 1, high while an accepted division is in progress.
REQ-009 SHALL have port done, output, 1, single-cycle pulse marking quot/rem/dbz valid.
REQ-010 SHALL have port quot, output, DW, unsigned quotient.
REQ-011 SHALL have port rem, output, VW, unsigned remainder.
REQ-012 SHALL have port dbz, output, 1, divide-by-zero flag for the last result.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL accept start in IDLE or DONE: capture operands, clear the partial remainder, load an iteration counter with DW-1, enter RUN, raise busy.
REQ-015 SHALL use restoring division in RUN, one quotient bit per cycle, MSB first: shift the next dividend bit into a VW+1-bit partial remainder, trial-subtract the divisor, and keep the difference with quotient bit 1 if it is non-negative, else restore with quotient bit 0.
REQ-016 SHALL size the trial subtraction at VW+1 bits so that no carry is lost.
REQ-017 SHALL stay in RUN for exactly DW cycles, then enter DONE; with DW=8, done is high in the cycle after the 8th RUN edge.
REQ-018 SHALL deassert busy on the edge that enters DONE, assert done for exactly one cycle, and leave DONE for IDLE unless start is high.
REQ-019 SHALL hold quot, rem and dbz stable from DONE until the next accepted start; they SHALL not change during RUN.
REQ-020 SHALL ignore start, dividend and divisor while busy is high.
REQ-021 SHALL, when the divisor is 0, skip RUN and enter DONE on the next edge, setting quot to all ones, rem to dividend[VW-1:0] and dbz to 1.
REQ-022 SHALL clear dbz on every accepted non-zero division.
REQ-023 SHALL guarantee dividend == quot*divisor + rem and rem < divisor for every non-zero divisor.
REQ-024 SHALL, when start is high in DONE, accept the new operation; done pulses once and busy rises on the same edge (back-to-back operation).

Reset
REQ-025 SHALL, on rst_n low, asynchronously force the state to IDLE and busy, done, quot, rem, dbz and all internal registers to 0.
REQ-026 SHALL abort an in-progress division when rst_n is asserted; no done pulse follows reset release.
REQ-027 SHALL not accept start until the first rising clk edge after rst_n deasserts.

Structure
REQ-028 SHALL place the DW/VW defaults and the state encodings (IDLE=0, RUN=1, DONE=2, 2 bits) in the shared package div_pkg.
REQ-029 SHALL implement one iteration in a combinational sub-module div_step: inputs are the partial remainder, the next dividend bit and the divisor; outputs are the next partial remainder and the quotient bit.
REQ-030 SHALL have no combinational path from any input to any output.

Verification
REQ-031 SHALL cover: dividend=200, divisor=7, start 1 cycle -> busy 8 cycles, done 1 cycle later, quot=28, rem=4, dbz=0.
REQ-032 SHALL cover: 255/1 -> quot=255, rem=0; 0/15 -> quot=0, rem=0; 15/15 -> quot=1, rem=0.
REQ-033 SHALL cover: 37/0 -> done on the 2nd edge after start, quot=8'hFF, rem=5, dbz=1; a following 37/3 -> quot=12, rem=1, dbz=0.
REQ-034 SHALL cover: start=1 with 9/2 asserted in RUN cycle 3 of 100/9 -> it is ignored, and the result is quot=11, rem=1.
REQ-035 SHALL cover: rst_n pulsed low in RUN cycle 4 -> outputs read 0 immediately, no done pulse; a new 50/6 -> quot=8, rem=2.
REQ-036 SHALL cover: start held high across done with 60/4 then 61/4 -> done pulses twice, giving 15/0 then 15/1, with no IDLE gap.
